assoc_ram: RTL
==============

ASSOC_RAM -- requirements
Module: assoc_ram

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, tag/address width in bits.
REQ-002 SHALL have parameter DATA_W, default 8, data width in bits.
REQ-003 SHALL have parameter DEPTH, default 4, entry count; power of two, >=2.
REQ-004 SHALL have port clock  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port req_valid  input  1  request present.
REQ-007 SHALL have port req_ready  output  1  request accepted when high with req_valid.
REQ-008 SHALL have port write  input  1  1 = write, 0 = read; sampled on accept.
REQ-009 SHALL have port address  input  ADDR_W  lookup tag; sampled on accept.
REQ-010 SHALL have port dataIn  input  DATA_W  write data; sampled on accept.
REQ-011 SHALL have port resp_valid  output  1  one-cycle response strobe.
REQ-012 SHALL have port dataOut  output  DATA_W  read data, valid with resp_valid.
REQ-013 SHALL have port hit  output  1  1 = tag matched, valid with resp_valid.

Function
REQ-014 SHALL store DEPTH entries of {valid, tag[ADDR_W], data[DATA_W]} plus a victim pointer of log2(DEPTH) bits.
REQ-015 SHALL run FSM IDLE -> SEARCH -> RESP -> IDLE; req_ready = 1 only in IDLE.
REQ-016 SHALL latch write/address/dataIn on the edge where req_valid && req_ready, enter SEARCH with scan index 0.
REQ-017 SHALL in SEARCH compare one entry per cycle, index 0 upward; match = valid && tag == latched address.
REQ-018 SHALL on match at index k: read loads dataOut from entry; write overwrites entry data only; hit = 1; go RESP.
REQ-019 SHALL, during scan, record the lowest-index invalid entry.
REQ-020 SHALL on no match after index DEPTH-1: hit = 0; read drives dataOut = 0; write allocates entry (valid=1, tag, data) into lowest invalid entry, else into victim-pointer entry, then victim pointer increments modulo DEPTH.
REQ-021 SHALL advance victim pointer only on replacement of a valid entry; never on hit or allocation into an invalid entry.
REQ-022 SHALL hold resp_valid high for exactly the one cycle spent in RESP; response for match at index k appears k+2 cycles after accept edge, miss DEPTH+1 cycles.
REQ-023 SHALL hold dataOut and hit stable outside resp_valid until next response.
REQ-024 SHALL ignore input changes between accept and RESP; req_valid while busy is not accepted and has no effect.
REQ-025 SHALL make tag duplicates impossible: a write to an existing tag always updates, never allocates.

Reset
REQ-026 SHALL on reset: state IDLE, req_ready 1, resp_valid 0, hit 0, dataOut 0, victim pointer 0, all valid bits 0 (unless REQ-028).
REQ-027 SHALL abort any in-flight request on reset with no entry modified and no response emitted.

Configuration
REQ-028 SHALL, with ASSOC_RAM_PRELOAD_EN defined, reset entry i to valid=1, tag=i, data=i (truncated to widths); without it all entries reset invalid with tag/data 0.

Verification (DEPTH=4, ADDR_W=DATA_W=8, no preload unless stated)
REQ-029 SHALL cover: after reset, read 0x03 -> resp_valid 5 cycles after accept, hit=0, dataOut=0x00.
REQ-030 SHALL cover: write 0x10/0xAA then read 0x10 -> write hit=0 (allocated entry 0); read hit=1, dataOut=0xAA, resp 2 cycles after accept.
REQ-031 SHALL cover: write tags 0x10,0x20,0x30,0x40 then 0x50/0x55 -> 0x50 replaces entry 0, victim pointer 1; read 0x10 -> hit=0; write 0x60 -> replaces entry 1.
REQ-032 SHALL cover: write 0x30/0x77 on existing tag -> hit=1, entry 2 data 0x77, victim pointer unchanged.
REQ-033 SHALL cover: reset asserted in SEARCH of a write -> resp_valid 0 at once, req_ready 1, no entry changed.
REQ-034 SHALL cover: with ASSOC_RAM_PRELOAD_EN, read 0x02 -> hit=1, dataOut=0x02, resp 4 cycles after accept.

Source files
------------

// File: rtl/assoc_ram.sv
// assoc_ram: small fully associative tag/data store with a sequential search.
//
// Each request is accepted in IDLE. Its tag is then compared against one entry
// per cycle, starting at entry 0. A hit ends the search early. A miss finishes
// after the last entry.
//
// On a write miss the new entry goes into the lowest-index invalid slot. If no
// slot is invalid, it replaces the slot named by the round-robin victim pointer.
//
// The response is a single-cycle resp_valid strobe. hit and dataOut keep their
// values until the next response.
//
// Ports:
//   clock       sole clock, rising edge
//   reset       asynchronous, active-high reset
//   req_valid   request present
//   req_ready   request accepted when high together with req_valid (IDLE only)
//   write       1 = write, 0 = read (sampled on accept)
//   address     lookup tag (sampled on accept)
//   dataIn      write data (sampled on accept)
//   resp_valid  one-cycle response strobe
//   dataOut     read data, valid with resp_valid
//   hit         1 = tag matched, valid with resp_valid
//
// Optional feature: define ASSOC_RAM_PRELOAD_EN to reset entry i to
// {valid=1, tag=i, data=i}. Without it, all entries reset invalid and zero.

module assoc_ram #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              write,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] dataIn,
    output logic              resp_valid,
    output logic [DATA_W-1:0] dataOut,
    output logic              hit
);

    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic              r_valid [DEPTH];
    logic [ADDR_W-1:0] r_tag   [DEPTH];
    logic [DATA_W-1:0] r_data  [DEPTH];

    logic [IDX_W-1:0]  r_vp;
    logic [IDX_W-1:0]  r_idx;
    logic [IDX_W-1:0]  r_free_idx;
    logic              r_free_found;
    logic              r_write;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_din;
    logic [DATA_W-1:0] r_dout;
    logic              r_hit;

    logic              w_match;
    logic              w_last;
    logic              w_alloc_free;
    logic [IDX_W-1:0]  w_alloc_idx;

    assign w_match = r_valid[r_idx] && (r_tag[r_idx] == r_addr);
    assign w_last  = (r_idx == IDX_W'(DEPTH - 1));

    // The entry under inspection in the final cycle can still be the lowest
    // free slot. The registered free record only covers the earlier entries.
    assign w_alloc_free = r_free_found || !r_valid[r_idx];
    assign w_alloc_idx  = r_free_found     ? r_free_idx :
                          !r_valid[r_idx]  ? r_idx      : r_vp;

    assign req_ready  = (r_state == IDLE);
    assign resp_valid = (r_state == RESP);
    assign dataOut    = r_dout;
    assign hit        = r_hit;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (req_valid) w_state_nxt = SEARCH;
            SEARCH:  if (w_match || w_last) w_state_nxt = RESP;
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
`ifdef ASSOC_RAM_PRELOAD_EN
                r_valid[i] <= 1'b1;
                r_tag[i]   <= ADDR_W'(i);
                r_data[i]  <= DATA_W'(i);
`else
                r_valid[i] <= 1'b0;
                r_tag[i]   <= '0;
                r_data[i]  <= '0;
`endif
            end
            r_vp         <= '0;
            r_idx        <= '0;
            r_free_idx   <= '0;
            r_free_found <= 1'b0;
            r_write      <= 1'b0;
            r_addr       <= '0;
            r_din        <= '0;
            r_dout       <= '0;
            r_hit        <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_write      <= write;
                        r_addr       <= address;
                        r_din        <= dataIn;
                        r_idx        <= '0;
                        r_free_idx   <= '0;
                        r_free_found <= 1'b0;
                    end
                end
                SEARCH: begin
                    if (w_match) begin
                        r_hit <= 1'b1;
                        if (r_write) begin
                            r_data[r_idx] <= r_din;
                        end else begin
                            r_dout <= r_data[r_idx];
                        end
                    end else if (w_last) begin
                        r_hit <= 1'b0;
                        if (r_write) begin
                            r_valid[w_alloc_idx] <= 1'b1;
                            r_tag[w_alloc_idx]   <= r_addr;
                            r_data[w_alloc_idx]  <= r_din;
                            // Only a replacement of a live entry moves the victim pointer.
                            if (!w_alloc_free) begin
                                r_vp <= r_vp + 1'b1;
                            end
                        end else begin
                            r_dout <= '0;
                        end
                    end else begin
                        if (!r_valid[r_idx] && !r_free_found) begin
                            r_free_found <= 1'b1;
                            r_free_idx   <= r_idx;
                        end
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
